tx: RTL and testbench

- Single-branch (I or Q) QPSK transmitter baseband path; the mirror of the receive matched-filter/decision path.
- Generates symbols from an internal PRBS9 or an external bit, maps bit to ±1 (or 0 when muted), upsamples by 4 and pulse-shapes them.
- Uses a 24-tap polyphase FIR built on the same RRC coefficient set as the receiver. Output is one signed 8-bit sample per enabled clock, which feeds the channel/DAC side and the loopback into the receiver.

---
 rtl/tx_pkg.sv | 46 ++++
 rtl/tx_prbs9.sv | 25 ++
 rtl/tx.sv | 81 ++++++++
 tb/tb_tx.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared constants and types for the QPSK single-branch transmit path
// and its matching receive path.
package tx_pkg;

    localparam int OS     = 4;
    localparam int NTAPS  = 24;
    localparam int NB_OUT = 8;
    localparam int NPH    = NTAPS / OS;
    localparam int ACC_W  = 11;

    localparam logic [8:0] PRBS_SEED    = 9'h1FF;
    localparam int         PRBS_TAP_OUT = 8;
    localparam int         PRBS_TAP_FB  = 4;

    // RRC pulse, signed Q1.7, shared with the receiver matched filter.
    localparam logic signed [7:0] COEF [NTAPS] = '{
        8'sh00, 8'shFE, 8'shFF, 8'sh00, 8'sh02, 8'sh00, 8'shFB, 8'shF5,
        8'shF9, 8'sh0A, 8'sh25, 8'sh3E, 8'sh48, 8'sh3E, 8'sh25, 8'sh0A,
        8'shF9, 8'shF5, 8'shFB, 8'sh00, 8'sh02, 8'sh00, 8'shFF, 8'shFE
    };

    // Symbol: valid=0 is a zero symbol, otherwise sign=1 means -1.
    typedef struct packed {
        logic valid;
        logic sign;
    } sym_t;

    localparam sym_t SYM_ZERO = '0;

    function automatic sym_t encode_sym(input logic b, input logic mute);
        sym_t s;
        s.valid = ~mute;
        s.sign  = ~b;
        return s;
    endfunction

    function automatic logic signed [NB_OUT-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        if (v > 11'sd127)
            return 8'sd127;
        else if (v < -11'sd128)
            return -8'sd128;
        else
            return v[NB_OUT-1:0];
    endfunction

endpackage

// File: rtl/tx_prbs9.sv
// PRBS9 generator, x^9+x^5+1 Fibonacci form; advances only when asked.
module tx_prbs9
    import tx_pkg::*;
#(
    parameter logic [8:0] SEED = PRBS_SEED
) (
    input  logic clk,
    input  logic rst,
    input  logic advance,
    output logic o_bit
);

    logic [8:0] state;

    assign o_bit = state[PRBS_TAP_OUT];

    // LFSR state: reload seed on reset, shift feedback into bit 0 on advance.
    always_ff @(posedge clk) begin
        if (rst)
            state <= SEED;
        else if (advance)
            state <= {state[7:0], state[PRBS_TAP_OUT] ^ state[PRBS_TAP_FB]};
    end

endmodule

// File: rtl/tx.sv
// Single-branch QPSK transmitter: symbol source, x4 upsampling and
// multiplier-free 24-tap polyphase RRC shaping.
module tx
    import tx_pkg::*;
#(
    parameter logic [8:0] SEED = PRBS_SEED
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     i_sel,
    input  logic                     i_bit,
    input  logic                     i_mute,
    output logic signed [NB_OUT-1:0] o_tx,
    output logic                     o_bit,
    output logic                     o_load
);

    logic [1:0]               phase_cnt;
    logic [1:0]               q;
    sym_t                     sreg [NPH];
    logic                     load;
    logic                     prbs_bit;
    logic                     src_bit;
    logic signed [ACC_W-1:0]  acc;

    assign load    = enable && (phase_cnt == 2'd0);
    assign q       = phase_cnt - 2'd1;
    assign src_bit = i_sel ? i_bit : prbs_bit;

    tx_prbs9 #(.SEED(SEED)) u_prbs (
        .clk     (clk),
        .rst     (rst),
        .advance (load),
        .o_bit   (prbs_bit)
    );

    // Polyphase sum for phase q: each tap adds, subtracts or skips h[4m+q].
    always_comb begin
        logic [4:0]              idx;
        logic signed [ACC_W-1:0] h;
        acc = '0;
        idx = '0;
        h   = '0;
        for (int unsigned m = 0; m < NPH; m++) begin
            idx = 5'(OS * m) + 5'(q);
            h   = ACC_W'(COEF[idx]);
            if (sreg[m].valid) begin
                if (sreg[m].sign)
                    acc = acc - h;
                else
                    acc = acc + h;
            end
        end
    end

    // Phase counter, symbol delay line and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_cnt <= '0;
            for (int unsigned m = 0; m < NPH; m++)
                sreg[m] <= SYM_ZERO;
            o_tx   <= '0;
            o_bit  <= 1'b0;
            o_load <= 1'b0;
        end else if (enable) begin
            phase_cnt <= phase_cnt + 2'd1;
            o_tx      <= sat_out(acc);
            o_load    <= load;
            if (load) begin
                for (int unsigned m = NPH - 1; m > 0; m--)
                    sreg[m] <= sreg[m-1];
                sreg[0] <= encode_sym(src_bit, i_mute);
                o_bit   <= src_bit & ~i_mute;
            end
        end else begin
            o_load <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tx.sv
// Self-checking bench for tx: directed scenarios plus random stimulus,
// compared against a symbol-history convolution model.
module tb_tx;

    logic              clk = 1'b0;
    logic              rst, enable, i_sel, i_bit, i_mute;
    logic signed [7:0] o_tx;
    logic              o_bit, o_load;

    always #5 clk = ~clk;

    tx #(.SEED(9'h1FF)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .i_sel  (i_sel),
        .i_bit  (i_bit),
        .i_mute (i_mute),
        .o_tx   (o_tx),
        .o_bit  (o_bit),
        .o_load (o_load)
    );

    int checks = 0;
    int errors = 0;

    int h [24] = '{0, -2, -1, 0, 2, 0, -5, -11, -7, 10, 37, 62,
                   72, 62, 37, 10, -7, -11, -5, 0, 2, 0, -1, -2};

    // Model state: symbol values (+1/-1/0), newest first.
    int hist [6];
    int edges;
    int prbs;
    int m_tx, m_bit, m_load;

    int prbs_bits [1022];
    int nbits;
    int loads;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // One clock edge with given inputs; model updated, then all outputs compared.
    task automatic step(input logic r, input logic e, input logic s,
                        input logic b, input logic mu);
        int q, acc, bitv;
        rst = r; enable = e; i_sel = s; i_bit = b; i_mute = mu;
        @(posedge clk);
        if (r) begin
            for (int m = 0; m < 6; m++) hist[m] = 0;
            edges = 0; prbs = 'h1FF;
            m_tx = 0; m_bit = 0; m_load = 0;
        end else if (e) begin
            q = (edges + 3) % 4;
            acc = 0;
            for (int m = 0; m < 6; m++) acc += hist[m] * h[4*m + q];
            m_tx = sat8(acc);
            if (edges % 4 == 0) begin
                bitv = s ? int'(b) : ((prbs >> 8) & 1);
                prbs = ((prbs << 1) & 'h1FE) | (((prbs >> 8) ^ (prbs >> 4)) & 1);
                for (int m = 5; m > 0; m--) hist[m] = hist[m-1];
                hist[0] = mu ? 0 : (bitv ? 1 : -1);
                m_bit = mu ? 0 : bitv;
                m_load = 1;
            end else begin
                m_load = 0;
            end
            edges++;
        end else begin
            m_load = 0;
        end
        #1;
        check("o_tx",   int'(o_tx),   m_tx);
        check("o_bit",  int'(o_bit),  m_bit);
        check("o_load", int'(o_load), m_load);
    endtask

    initial begin
        // Reset state
        step(1, 1, 1, 0, 0);
        check("reset_tx",   int'(o_tx),   0);
        check("reset_load", int'(o_load), 0);

        // Impulse: one +1 symbol then muted loads -> o_tx walks h[0..23]
        step(0, 1, 1, 1, 0);
        for (int k = 0; k < 28; k++) begin
            step(0, 1, 1, 0, 1);
            check("impulse", int'(o_tx), (k < 24) ? h[k] : 0);
        end

        // All-ones steady state
        step(1, 1, 1, 1, 0);
        for (int k = 0; k < 32; k++) begin
            step(0, 1, 1, 1, 0);
            if (k >= 21) check("all_ones", int'(o_tx), (k % 2) ? 62 : 59);
        end

        // Enable gating 1010 during all-ones stream
        loads = 0;
        for (int k = 0; k < 32; k++) begin
            step(0, (k % 2 == 0), 1, 1, 0);
            if (k % 2 == 1) check("gated_hold_load", int'(o_load), 0);
            loads += int'(o_load);
            check("gated_tx", int'(o_tx), 59 + 3 * ((edges + 1) % 2));
        end
        check("gated_load_count", loads, 4);

        // All-zeros steady state
        step(1, 1, 1, 0, 0);
        for (int k = 0; k < 32; k++) begin
            step(0, 1, 1, 0, 0);
            if (k >= 21) check("all_zeros", int'(o_tx), (k % 2) ? -62 : -59);
        end

        // Mid-symbol reset at phase 2, then impulse reproduces from h[0]
        for (int k = 0; k < 6; k++) step(0, 1, 1, 1, 0);
        step(1, 1, 1, 1, 0);
        check("midrst_tx",   int'(o_tx),   0);
        check("midrst_load", int'(o_load), 0);
        step(0, 1, 1, 1, 0);
        for (int k = 0; k < 26; k++) begin
            step(0, 1, 1, 0, 1);
            check("impulse2", int'(o_tx), (k < 24) ? h[k] : 0);
        end

        // PRBS: two full periods of loads
        step(1, 1, 0, 0, 0);
        nbits = 0;
        for (int k = 0; k < 1022 * 4 && nbits < 1022; k++) begin
            step(0, 1, 0, $urandom_range(0, 1), 0);
            if (o_load) begin
                prbs_bits[nbits] = int'(o_bit);
                nbits++;
            end
        end
        check("prbs_nbits", nbits, 1022);
        check("prbs_first", prbs_bits[0], 1);
        begin
            int ones, diffs;
            ones = 0; diffs = 0;
            for (int k = 0; k < 511; k++) begin
                ones += prbs_bits[k];
                if (prbs_bits[k] != prbs_bits[k + 511]) diffs++;
            end
            check("prbs_ones", ones, 256);
            check("prbs_period", diffs, 0);
        end

        // Random stimulus with occasional reset
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 4) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
